// File: rtl/lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lfsr_seq_ctrl
//
// Sequencer for the LFSR pattern generator. A start command loads a seed and a
// word count. The Galois LFSR is then streamed out on a valid/ready handshake,
// stepping once per accepted word. A one-cycle done pulse marks the end of a
// completed run.
//
// Optional feature macro: LFSR_WRAP_DET_EN
//   defined     : the effective seed is captured at start, and wrap_pulse fires
//                 one cycle after an accepted transfer whose next LFSR value
//                 equals that seed.
//   not defined : wrap_pulse is tied to 0 and no capture register is built.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle run command, honoured only in IDLE
//   abort      in   terminates a run in RUN (no done pulse)
//   seed_in    in   [WIDTH]  initial LFSR state (0 is replaced by 1)
//   count_in   in   [CNT_W]  number of words to emit (0 -> immediate done)
//   out_data   out  [WIDTH]  current LFSR state
//   out_valid  out  out_data is valid
//   out_ready  in   consumer accepts out_data
//   busy       out  high while in RUN
//   done       out  one-cycle pulse when a run completes
//   seed_fixed out  sticky per run: seed was zero and was replaced by 1
//   wrap_pulse out  one-cycle pulse when the LFSR returns to its start state
// -----------------------------------------------------------------------------
module lfsr_seq_ctrl #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [CNT_W-1:0] count_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             seed_fixed,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] lfsr_q;
    logic [CNT_W-1:0] remaining_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             seed_fixed_q;

    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] seed_eff_d;
    logic             load_d;
    logic             accept_d;

    always_comb begin
        lfsr_d     = {lfsr_q[WIDTH-2:0], 1'b0} ^ (lfsr_q[WIDTH-1] ? TAPS : '0);
        // An all-zero seed would lock the LFSR, so it is replaced by 1.
        seed_eff_d = (seed_in == '0) ? WIDTH'(1) : seed_in;
        load_d     = (state_q == S_IDLE) && start && (count_in != '0);
        // abort outranks the handshake, so an aborted beat is never a transfer.
        accept_d   = (state_q == S_RUN) && out_ready && !abort;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lfsr_q       <= '0;
            remaining_q  <= '0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            seed_fixed_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (load_d) begin
                        lfsr_q       <= seed_eff_d;
                        seed_fixed_q <= (seed_in == '0);
                        remaining_q  <= count_in;
                        out_valid_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_RUN;
                    end else if (start) begin
                        // Zero-length run: straight to the done pulse.
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (accept_d) begin
                        lfsr_q      <= lfsr_d;
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            out_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LFSR_WRAP_DET_EN
    logic [WIDTH-1:0] seed_cap_q;
    logic             wrap_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_cap_q <= '0;
            wrap_q     <= 1'b0;
        end else begin
            if (load_d) begin
                seed_cap_q <= seed_eff_d;
            end
            wrap_q <= accept_d && (lfsr_d == seed_cap_q);
        end
    end

    assign wrap_pulse = wrap_q;
`else
    assign wrap_pulse = 1'b0;
`endif

    assign out_data   = lfsr_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign seed_fixed = seed_fixed_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for lfsr_seq_ctrl. Expected words come from a polynomial model
// (multiply by x modulo x^4+x+1) built into a queue per run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfsr_seq_ctrl;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 8;
    localparam int TAPS_I = 3;
`ifdef LFSR_WRAP_DET_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] seed_in = '0;
    logic [CNT_W-1:0] count_in = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             seed_fixed;
    logic             wrap_pulse;

    int checks   = 0;
    int failures = 0;
    int words[$];

    lfsr_seq_ctrl #(.WIDTH(WIDTH), .TAPS(4'b0011), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .seed_in    (seed_in),
        .count_in   (count_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .seed_fixed (seed_fixed),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    // Multiply the field element by x; reduce by x^4 = x + 1 on overflow.
    function automatic int poly_mul_x(int v);
        int d;
        d = v * 2;
        if (d >= 16) d = (d - 16) ^ TAPS_I;
        return d;
    endfunction

    // Fills words[] with the expected stream (n+1 entries: the last is the
    // value following the final accepted word).
    function automatic void build_model(int seed, int n);
        int v;
        words.delete();
        v = (seed == 0) ? 1 : seed;
        for (int i = 0; i <= n; i++) begin
            words.push_back(v);
            v = poly_mul_x(v);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if ({out_data, out_valid, busy, done, seed_fixed, wrap_pulse} !== 9'b0) begin
            failures++;
            $display("FAIL reset outputs got=%b exp=%b",
                     {out_data, out_valid, busy, done, seed_fixed, wrap_pulse}, 9'b0);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle valid/busy/done got=%b%b%b exp=000", out_valid, busy, done);
        end
        $display("reset: checked");
    endtask

    // One run: rmode 0 = ready always 1, 1 = pattern 1,0,0,1,1, 2 = random.
    // abort_after >= 0 asserts abort (with ready=1) once that many words moved.
    // busy_start pulses a conflicting start during the run.
    task automatic test_stream(input string name, input int seed, input int count,
                               input int rmode, input int abort_after, input bit busy_start);
        int  k;
        int  cyc;
        int  eff;
        bit  r;
        bit  a;
        bit  aborted;
        bit  exp_wrap;
        bit  pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        build_model(seed, count);
        eff      = (seed == 0) ? 1 : seed;
        seed_in  = WIDTH'(seed);
        count_in = CNT_W'(count);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        checks++;
        if (seed_fixed !== (seed == 0)) begin
            failures++;
            $display("FAIL %s seed_fixed got=%b exp=%b", name, seed_fixed, (seed == 0));
        end
        k = 0; cyc = 0; aborted = 1'b0;
        while (k < count && cyc < 2000) begin
            case (rmode)
                0:       r = 1'b1;
                1:       r = pat[cyc % 5];
                default: r = 1'($urandom_range(0, 1));
            endcase
            a = (abort_after >= 0) && (k == abort_after);
            if (a) r = 1'b1;
            if (busy_start && cyc == 1) begin
                start    = 1'b1;
                seed_in  = WIDTH'(eff ^ 4'hF);
                count_in = CNT_W'(1);
            end
            out_ready = r;
            abort     = a;
            checks++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || out_data !== WIDTH'(words[k])) begin
                failures++;
                $display("FAIL %s word[%0d] got data=%0h v=%b b=%b d=%b exp data=%0h v=1 b=1 d=0",
                         name, k, out_data, out_valid, busy, done, words[k]);
            end
            tick();
            start = 1'b0;
            abort = 1'b0;
            if (a) begin
                aborted = 1'b1;
                break;
            end
            exp_wrap = r && WRAP_EN && (words[k+1] == eff);
            checks++;
            if (wrap_pulse !== exp_wrap) begin
                failures++;
                $display("FAIL %s wrap after word[%0d] got=%b exp=%b", name, k, wrap_pulse, exp_wrap);
            end
            if (r) k++;
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (cyc >= 2000) begin
            failures++;
            $display("FAIL %s timeout got=%0d words exp=%0d", name, k, count);
        end
        if (aborted) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                failures++;
                $display("FAIL %s abort v/b/d got=%b%b%b exp=000", name, out_valid, busy, done);
            end
            tick();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL %s abort_no_done d/v got=%b%b exp=00", name, done, out_valid);
            end
        end else begin
            checks++;
            if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s done_pulse d/v/b got=%b%b%b exp=100", name, done, out_valid, busy);
            end
            tick();
            checks++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL %s after_done d/v/b got=%b%b%b exp=000", name, done, out_valid, busy);
            end
        end
        checks++;
        if (seed_fixed !== (seed == 0)) begin
            failures++;
            $display("FAIL %s seed_fixed_hold got=%b exp=%b", name, seed_fixed, (seed == 0));
        end
        $display("run %s: seed=%0h count=%0d words=%0d aborted=%0d", name, seed, count, k, aborted);
    endtask

    task automatic test_count_zero();
        seed_in  = 4'h5;
        count_in = '0;
        start    = 1'b1;
        tick();
        // start during DONE must be ignored
        count_in = CNT_W'(3);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL count_zero d/v/b got=%b%b%b exp=100", done, out_valid, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_in_done d/v/b got=%b%b%b exp=000", done, out_valid, busy);
        end
        tick();
        $display("count_zero: checked");
    endtask

    task automatic test_rst_mid_run();
        seed_in  = '0;
        count_in = CNT_W'(10);
        start    = 1'b1;
        tick();
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_data, out_valid, busy, done, seed_fixed, wrap_pulse} !== 9'b0) begin
            failures++;
            $display("FAIL rst_mid_run outputs got=%b exp=%b",
                     {out_data, out_valid, busy, done, seed_fixed, wrap_pulse}, 9'b0);
        end
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done d/v got=%b%b exp=00", done, out_valid);
        end
        $display("rst_mid_run: checked");
    endtask

    initial begin
        test_reset();
        test_stream("basic", 1, 5, 0, -1, 1'b0);
        test_stream("period", 1, 20, 0, -1, 1'b0);
        test_stream("zero_seed", 0, 2, 0, -1, 1'b0);
        test_stream("backpressure", 1, 3, 1, -1, 1'b0);
        test_stream("abort", 1, 10, 0, 2, 1'b0);
        test_stream("after_abort", 8, 1, 0, -1, 1'b0);
        test_rst_mid_run();
        test_stream("start_busy", 6, 4, 0, -1, 1'b1);
        test_count_zero();
        test_stream("max_count", 9, 255, 0, -1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            test_stream("random", int'($urandom_range(0, 15)), int'($urandom_range(1, 20)),
                        2, -1, 1'b0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
